// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding, defaults and width helper for the Stein GCD engine
package gcd_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        STRIP,
        REDUCE,
        DONE
    } state_t;

    // k never exceeds WIDTH-1 shifts, so this always leaves headroom
    function automatic int k_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/gcd_stein_if.sv
// rtl/gcd_stein_if.sv - start/done request interface for the Stein GCD engine
interface gcd_stein_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [WIDTH-1:0] answer;
    logic             done;
    logic             busy;
    logic             zero_in;
    logic [CNT_W-1:0] iterations;

    modport master (
        output start, Ain, Bin,
        input  answer, done, busy, zero_in, iterations
    );

    modport slave (
        input  start, Ain, Bin,
        output answer, done, busy, zero_in, iterations
    );
endinterface

// File: rtl/gcd_stein_dp.sv
// rtl/gcd_stein_dp.sv - operand registers, shifter, comparator and subtractor for binary GCD
module gcd_stein_dp
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  state_t           state,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    output logic             zero_op,
    output logic             both_even,
    output logic             reduce_eq,
    output logic [WIDTH-1:0] result
);
    localparam int KW = k_width(WIDTH);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [KW-1:0]    k;

    assign zero_op   = (a == '0) || (b == '0);
    assign both_even = ~a[0] & ~b[0];
    // Equality only terminates once both sides are odd
    assign reduce_eq = a[0] & b[0] & (a == b);
    assign result    = zero_op ? (a | b) : (a << k);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a <= '0;
            b <= '0;
            k <= '0;
        end else if (load) begin
            a <= ain;
            b <= bin;
            k <= '0;
        end else begin
            case (state)
                STRIP: begin
                    if (both_even) begin
                        a <= a >> 1;
                        b <= b >> 1;
                        k <= k + 1'b1;
                    end
                end
                REDUCE: begin
                    if (!a[0])       a <= a >> 1;
                    else if (!b[0])  b <= b >> 1;
                    else if (a == b) a <= a;
                    else if (a > b)  a <= a - b;
                    else             b <= b - a;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gcd_stein.sv
// rtl/gcd_stein.sv - multi-cycle binary GCD coprocessor: control FSM, cycle counter, result registers
module gcd_stein
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    gcd_stein_if.slave  bus
);
    state_t           state;
    state_t           state_next;
    logic             load;
    logic             finish;
    logic             zero_op;
    logic             both_even;
    logic             reduce_eq;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] answer_q;
    logic [CNT_W-1:0] iterations_q;
    logic             zero_in_q;

    gcd_stein_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .state     (state),
        .ain       (bus.Ain),
        .bin       (bus.Bin),
        .zero_op   (zero_op),
        .both_even (both_even),
        .reduce_eq (reduce_eq),
        .result    (result)
    );

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (zero_op) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = STRIP;
                end
            end
            STRIP: begin
                if (!both_even) state_next = REDUCE;
            end
            REDUCE: begin
                if (reduce_eq) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // iterations includes the cycle that moves into DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            answer_q     <= '0;
            iterations_q <= '0;
            zero_in_q    <= 1'b0;
        end else begin
            if (load)
                cnt <= '0;
            else if (state == CHECK || state == STRIP || state == REDUCE)
                cnt <= cnt_inc;
            if (state == CHECK)
                zero_in_q <= zero_op;
            if (finish) begin
                answer_q     <= result;
                iterations_q <= cnt_inc;
            end
        end
    end

    assign bus.answer     = answer_q;
    assign bus.iterations = iterations_q;
    assign bus.zero_in    = zero_in_q;
    assign bus.done       = (state == DONE);
    assign bus.busy       = (state != IDLE);

endmodule
